// File: rtl/decode_stage_pkg.sv
// RV32I decode definitions shared by the decode stage and its immediate generator.
package rv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    // Bit positions inside ex_ctrl
    localparam int CTRL_REG_WRITE   = 7;
    localparam int CTRL_MEM_READ    = 6;
    localparam int CTRL_MEM_WRITE   = 5;
    localparam int CTRL_BRANCH      = 4;
    localparam int CTRL_JAL         = 3;
    localparam int CTRL_JALR        = 2;
    localparam int CTRL_ALU_SRC_IMM = 1;
    localparam int CTRL_ILLEGAL     = 0;

    // ALU operation for OP / OP-IMM; SUB is only reachable from register-register ops
    function automatic alu_op_t aluFromFunct3(input logic [2:0] funct3,
                                              input logic       funct7b5,
                                              input logic       isRegReg);
        alu_op_t op;
        case (funct3)
            3'b000:  op = (isRegReg && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Combinational RV32I immediate extraction; all formats sign-extend from instr[31].
module imm_gen
    import rv_pkg::*;
(
    input  logic [31:0] instr,
    input  imm_fmt_t    fmt,
    output logic [31:0] imm
);

    // Select and assemble the immediate for the requested format
    always_comb begin
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: instruction decode, load-use hazard detection and the ID/EX register.
module decode_stage
    import rv_pkg::*;
#(
    parameter bit RESET_BUBBLE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    output logic        if_ready,
    input  logic [31:0] if_instr,
    input  logic [31:0] if_pc,
    output logic [4:0]  rf_srcA,
    output logic [4:0]  rf_srcB,
    input  logic [31:0] rf_outputA,
    input  logic [31:0] rf_outputB,
    input  logic        ex_ready,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_val,
    output logic [31:0] ex_rs2_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [3:0]  ex_alu_op,
    output logic [7:0]  ex_ctrl,
    input  logic        ex_load_pending,
    input  logic [4:0]  ex_load_rd,
    input  logic        flush
);

    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    imm_fmt_t    immFmt;
    alu_op_t     aluOp;
    logic [7:0]  ctrl;
    logic [31:0] imm;
    logic        useRs1, useRs2;
    logic        hazard, advance, accept;

    logic        exValid;
    logic [31:0] exPc, exRs1Val, exRs2Val, exImm;
    logic [4:0]  exRs1, exRs2, exRd;
    alu_op_t     exAluOp;
    logic [7:0]  exCtrl;

    assign opcode = if_instr[6:0];
    assign rd     = if_instr[11:7];
    assign funct3 = if_instr[14:12];
    assign rs1    = if_instr[19:15];
    assign rs2    = if_instr[24:20];

    assign rf_srcA = rs1;
    assign rf_srcB = rs2;

    imm_gen uImmGen (
        .instr (if_instr),
        .fmt   (immFmt),
        .imm   (imm)
    );

    // Decode opcode into control bits, ALU op, immediate format and source usage
    always_comb begin
        immFmt = IMM_NONE;
        aluOp  = ALU_ADD;
        ctrl   = 8'd0;
        useRs1 = 1'b1;
        useRs2 = 1'b0;
        case (opcode)
            OPC_LUI: begin
                immFmt = IMM_U;
                aluOp  = ALU_PASSB;
                useRs1 = 1'b0;
                ctrl[CTRL_REG_WRITE]   = 1'b1;
                ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPC_AUIPC: begin
                immFmt = IMM_U;
                useRs1 = 1'b0;
                ctrl[CTRL_REG_WRITE]   = 1'b1;
                ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPC_JAL: begin
                immFmt = IMM_J;
                useRs1 = 1'b0;
                ctrl[CTRL_REG_WRITE] = 1'b1;
                ctrl[CTRL_JAL]       = 1'b1;
            end
            OPC_JALR: begin
                immFmt = IMM_I;
                ctrl[CTRL_REG_WRITE]   = 1'b1;
                ctrl[CTRL_JALR]        = 1'b1;
                ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPC_BRANCH: begin
                immFmt = IMM_B;
                useRs2 = 1'b1;
                // beq/bne compare by subtraction; the rest by signed/unsigned set-less-than
                aluOp  = (funct3[2:1] == 2'b10) ? ALU_SLT :
                         (funct3[2:1] == 2'b11) ? ALU_SLTU : ALU_SUB;
                ctrl[CTRL_BRANCH] = 1'b1;
            end
            OPC_LOAD: begin
                immFmt = IMM_I;
                ctrl[CTRL_REG_WRITE]   = 1'b1;
                ctrl[CTRL_MEM_READ]    = 1'b1;
                ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPC_STORE: begin
                immFmt = IMM_S;
                useRs2 = 1'b1;
                ctrl[CTRL_MEM_WRITE]   = 1'b1;
                ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPC_OP_IMM: begin
                immFmt = IMM_I;
                aluOp  = aluFromFunct3(funct3, if_instr[30], 1'b0);
                ctrl[CTRL_REG_WRITE]   = 1'b1;
                ctrl[CTRL_ALU_SRC_IMM] = 1'b1;
            end
            OPC_OP: begin
                useRs2 = 1'b1;
                aluOp  = aluFromFunct3(funct3, if_instr[30], 1'b1);
                ctrl[CTRL_REG_WRITE] = 1'b1;
            end
            OPC_MISC_MEM, OPC_SYSTEM: begin
                // Treated as NOPs: no side effects leave decode
            end
            default: begin
                ctrl[CTRL_ILLEGAL] = 1'b1;
            end
        endcase
        if (rd == 5'd0) begin
            ctrl[CTRL_REG_WRITE] = 1'b0;
        end
    end

    // Load-use hazard against the instruction currently in execute
    always_comb begin
        hazard = ex_load_pending && (ex_load_rd != 5'd0) &&
                 ((useRs1 && (ex_load_rd == rs1)) || (useRs2 && (ex_load_rd == rs2)));
    end

    assign advance  = !exValid || ex_ready;
    assign if_ready = advance && !hazard && !flush && !reset;
    assign accept   = if_valid && if_ready;

    // ID/EX pipeline register: reset, then flush, then hold/advance
    always_ff @(posedge clk) begin
        if (reset) begin
            exValid <= 1'b0;
            exCtrl  <= 8'd0;
            if (RESET_BUBBLE) begin
                exPc     <= 32'd0;
                exRs1Val <= 32'd0;
                exRs2Val <= 32'd0;
                exImm    <= 32'd0;
                exRs1    <= 5'd0;
                exRs2    <= 5'd0;
                exRd     <= 5'd0;
                exAluOp  <= ALU_ADD;
            end
        end else if (flush) begin
            exValid <= 1'b0;
            exCtrl  <= 8'd0;
        end else if (advance) begin
            if (accept) begin
                exValid  <= 1'b1;
                exCtrl   <= ctrl;
                exPc     <= if_pc;
                exRs1Val <= rf_outputA;
                exRs2Val <= rf_outputB;
                exImm    <= imm;
                exRs1    <= rs1;
                exRs2    <= rs2;
                exRd     <= rd;
                exAluOp  <= aluOp;
            end else begin
                exValid  <= 1'b0;
                exCtrl   <= 8'd0;
                exPc     <= 32'd0;
                exRs1Val <= 32'd0;
                exRs2Val <= 32'd0;
                exImm    <= 32'd0;
                exRs1    <= 5'd0;
                exRs2    <= 5'd0;
                exRd     <= 5'd0;
                exAluOp  <= ALU_ADD;
            end
        end
    end

    assign ex_valid   = exValid;
    assign ex_pc      = exPc;
    assign ex_rs1_val = exRs1Val;
    assign ex_rs2_val = exRs2Val;
    assign ex_imm     = exImm;
    assign ex_rs1     = exRs1;
    assign ex_rs2     = exRs2;
    assign ex_rd      = exRd;
    assign ex_alu_op  = exAluOp;
    assign ex_ctrl    = exCtrl;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: vector table plus hazard, stall, flush and reset sequences.
module tb_decode_stage;
    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [4:0]  rf_srcA, rf_srcB;
    logic [31:0] rf_outputA, rf_outputB;
    logic        ex_ready;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [3:0]  ex_alu_op;
    logic [7:0]  ex_ctrl;
    logic        ex_load_pending;
    logic [4:0]  ex_load_rd;
    logic        flush;

    always #5 clk = ~clk;

    decode_stage #(.RESET_BUBBLE(1'b1)) dut (
        .clk             (clk),
        .reset           (reset),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .rf_srcA         (rf_srcA),
        .rf_srcB         (rf_srcB),
        .rf_outputA      (rf_outputA),
        .rf_outputB      (rf_outputB),
        .ex_ready        (ex_ready),
        .ex_valid        (ex_valid),
        .ex_pc           (ex_pc),
        .ex_rs1_val      (ex_rs1_val),
        .ex_rs2_val      (ex_rs2_val),
        .ex_imm          (ex_imm),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_rd           (ex_rd),
        .ex_alu_op       (ex_alu_op),
        .ex_ctrl         (ex_ctrl),
        .ex_load_pending (ex_load_pending),
        .ex_load_rd      (ex_load_rd),
        .flush           (flush)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rfA;
        logic [31:0] rfB;
        logic [31:0] expImm;
        logic [4:0]  expRd;
        logic [4:0]  expRs1;
        logic [4:0]  expRs2;
        alu_op_t     expAlu;
        logic [7:0]  expCtrl;
    } vec_t;

    localparam int NUM_VECS = 15;
    vec_t vecs[NUM_VECS];

    int passCount  = 0;
    int totalCount = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end else begin
            passCount++;
        end
    endtask

    task automatic stepAfterEdge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // instr, pc, rfA, rfB, imm, rd, rs1, rs2, alu, ctrl
        vecs[0]  = '{32'hFFD08293, 32'h100, 32'd10,        32'd0,         32'hFFFFFFFD, 5'd5,  5'd1, 5'd29, ALU_ADD,   8'h82}; // addi x5,x1,-3
        vecs[1]  = '{32'h0021A423, 32'h104, 32'h00001000,  32'hDEADBEEF,  32'h00000008, 5'd8,  5'd3, 5'd2,  ALU_ADD,   8'h22}; // sw x2,8(x3)
        vecs[2]  = '{32'h123453B7, 32'h108, 32'd0,         32'd0,         32'h12345000, 5'd7,  5'd8, 5'd3,  ALU_PASSB, 8'h82}; // lui x7,0x12345
        vecs[3]  = '{32'h000002FF, 32'h10C, 32'd0,         32'd0,         32'h00000000, 5'd5,  5'd0, 5'd0,  ALU_ADD,   8'h01}; // opcode 0x7F
        vecs[4]  = '{32'h00100013, 32'h110, 32'd0,         32'd0,         32'h00000001, 5'd0,  5'd0, 5'd1,  ALU_ADD,   8'h02}; // addi x0,x0,1
        vecs[5]  = '{32'h00128333, 32'h114, 32'd77,        32'd5,         32'h00000000, 5'd6,  5'd5, 5'd1,  ALU_ADD,   8'h80}; // add x6,x5,x1
        vecs[6]  = '{32'h402081B3, 32'h118, 32'd9,         32'd4,         32'h00000000, 5'd3,  5'd1, 5'd2,  ALU_SUB,   8'h80}; // sub x3,x1,x2
        vecs[7]  = '{32'h40325213, 32'h11C, 32'h80000000,  32'd0,         32'h00000403, 5'd4,  5'd4, 5'd3,  ALU_SRA,   8'h82}; // srai x4,x4,3
        vecs[8]  = '{32'h40000093, 32'h120, 32'd0,         32'd0,         32'h00000400, 5'd1,  5'd0, 5'd0,  ALU_ADD,   8'h82}; // addi x1,x0,0x400
        vecs[9]  = '{32'hFFDFF0EF, 32'h124, 32'd0,         32'd0,         32'hFFFFFFFC, 5'd1,  5'd31,5'd29, ALU_ADD,   8'h88}; // jal x1,-4
        vecs[10] = '{32'h00208463, 32'h128, 32'd3,         32'd3,         32'h00000008, 5'd8,  5'd1, 5'd2,  ALU_SUB,   8'h10}; // beq x1,x2,+8
        vecs[11] = '{32'hFFC12503, 32'h12C, 32'h2000,      32'd0,         32'hFFFFFFFC, 5'd10, 5'd2, 5'd28, ALU_ADD,   8'hC2}; // lw x10,-4(x2)
        vecs[12] = '{32'h00008067, 32'h130, 32'h400,       32'd0,         32'h00000000, 5'd0,  5'd1, 5'd0,  ALU_ADD,   8'h06}; // jalr x0,0(x1)
        vecs[13] = '{32'h007332B3, 32'h134, 32'd1,         32'd2,         32'h00000000, 5'd5,  5'd6, 5'd7,  ALU_SLTU,  8'h80}; // sltu x5,x6,x7
        vecs[14] = '{32'hFFFFF417, 32'h138, 32'd0,         32'd0,         32'hFFFFF000, 5'd8,  5'd31,5'd31, ALU_ADD,   8'h82}; // auipc x8,0xFFFFF

        reset           = 1'b1;
        if_valid        = 1'b0;
        if_instr        = 32'h00000013;
        if_pc           = 32'd0;
        rf_outputA      = 32'd0;
        rf_outputB      = 32'd0;
        ex_ready        = 1'b1;
        ex_load_pending = 1'b0;
        ex_load_rd      = 5'd0;
        flush           = 1'b0;

        // Reset state
        stepAfterEdge();
        stepAfterEdge();
        check("reset_if_ready", {31'd0, if_ready}, 32'd0);
        check("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
        check("reset_ex_ctrl",  {24'd0, ex_ctrl},  32'd0);
        check("reset_ex_imm",   ex_imm,            32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Table-driven single-instruction decode
        for (int i = 0; i < NUM_VECS; i++) begin
            @(negedge clk);
            if_valid   = 1'b1;
            if_instr   = vecs[i].instr;
            if_pc      = vecs[i].pc;
            rf_outputA = vecs[i].rfA;
            rf_outputB = vecs[i].rfB;
            #1;
            check($sformatf("v%0d_rf_srcA", i), {27'd0, rf_srcA}, {27'd0, vecs[i].expRs1});
            check($sformatf("v%0d_rf_srcB", i), {27'd0, rf_srcB}, {27'd0, vecs[i].expRs2});
            check($sformatf("v%0d_if_ready", i), {31'd0, if_ready}, 32'd1);
            stepAfterEdge();
            check($sformatf("v%0d_ex_valid", i),   {31'd0, ex_valid},  32'd1);
            check($sformatf("v%0d_ex_rd", i),      {27'd0, ex_rd},     {27'd0, vecs[i].expRd});
            check($sformatf("v%0d_ex_imm", i),     ex_imm,             vecs[i].expImm);
            check($sformatf("v%0d_ex_alu_op", i),  {28'd0, ex_alu_op}, {28'd0, vecs[i].expAlu});
            check($sformatf("v%0d_ex_ctrl", i),    {24'd0, ex_ctrl},   {24'd0, vecs[i].expCtrl});
            check($sformatf("v%0d_ex_rs1_val", i), ex_rs1_val,         vecs[i].rfA);
            check($sformatf("v%0d_ex_rs2_val", i), ex_rs2_val,         vecs[i].rfB);
            check($sformatf("v%0d_ex_pc", i),      ex_pc,              vecs[i].pc);
        end

        // Load-use hazard on rs1: bubble, then accept once the load retires
        @(negedge clk);
        if_instr        = 32'h00128333;
        if_pc           = 32'h200;
        rf_outputA      = 32'd55;
        rf_outputB      = 32'd66;
        ex_load_pending = 1'b1;
        ex_load_rd      = 5'd5;
        #1;
        check("haz_rs1_if_ready", {31'd0, if_ready}, 32'd0);
        stepAfterEdge();
        check("haz_bubble_valid", {31'd0, ex_valid}, 32'd0);
        check("haz_bubble_ctrl",  {24'd0, ex_ctrl},  32'd0);
        @(negedge clk);
        ex_load_pending = 1'b0;
        #1;
        check("haz_clear_if_ready", {31'd0, if_ready}, 32'd1);
        stepAfterEdge();
        check("haz_accept_valid", {31'd0, ex_valid}, 32'd1);
        check("haz_accept_rd",    {27'd0, ex_rd},    32'd6);
        check("haz_accept_rs1v",  ex_rs1_val,        32'd55);

        // rs2 hazard, and sources the opcode does not use
        @(negedge clk);
        ex_load_pending = 1'b1;
        ex_load_rd      = 5'd1;
        #1;
        check("haz_rs2_if_ready", {31'd0, if_ready}, 32'd0);
        @(negedge clk);
        if_instr   = 32'h123453B7;
        ex_load_rd = 5'd8;
        #1;
        check("haz_lui_no_rs1", {31'd0, if_ready}, 32'd1);
        @(negedge clk);
        if_instr   = 32'h00100013;
        ex_load_rd = 5'd0;
        #1;
        check("haz_x0_no_hazard", {31'd0, if_ready}, 32'd1);
        @(negedge clk);
        ex_load_pending = 1'b0;

        // Stall: ex_ready low for three cycles holds ID/EX
        if_instr   = 32'h00128333;
        rf_outputA = 32'd123;
        ex_ready   = 1'b1;
        stepAfterEdge();
        @(negedge clk);
        ex_ready   = 1'b0;
        if_instr   = 32'h402081B3;
        rf_outputA = 32'd999;
        for (int c = 0; c < 3; c++) begin
            #1;
            check($sformatf("stall%0d_if_ready", c), {31'd0, if_ready}, 32'd0);
            stepAfterEdge();
            check($sformatf("stall%0d_valid", c), {31'd0, ex_valid}, 32'd1);
            check($sformatf("stall%0d_rd", c),    {27'd0, ex_rd},    32'd6);
            check($sformatf("stall%0d_alu", c),   {28'd0, ex_alu_op}, {28'd0, ALU_ADD});
            check($sformatf("stall%0d_rs1v", c),  ex_rs1_val,        32'd123);
            @(negedge clk);
        end
        flush = 1'b1;
        #1;
        check("flush_if_ready", {31'd0, if_ready}, 32'd0);
        stepAfterEdge();
        check("flush_valid", {31'd0, ex_valid}, 32'd0);
        check("flush_ctrl",  {24'd0, ex_ctrl},  32'd0);
        @(negedge clk);
        flush    = 1'b0;
        ex_ready = 1'b1;

        // Reset during a stall with flush asserted
        if_instr = 32'hFFD08293;
        stepAfterEdge();
        check("pre_reset_valid", {31'd0, ex_valid}, 32'd1);
        @(negedge clk);
        ex_ready = 1'b0;
        flush    = 1'b1;
        reset    = 1'b1;
        #1;
        check("rst_prio_if_ready", {31'd0, if_ready}, 32'd0);
        stepAfterEdge();
        check("rst_prio_valid", {31'd0, ex_valid}, 32'd0);
        check("rst_prio_ctrl",  {24'd0, ex_ctrl},  32'd0);
        check("rst_prio_imm",   ex_imm,            32'd0);
        check("rst_prio_rd",    {27'd0, ex_rd},    32'd0);
        check("rst_prio_rs1v",  ex_rs1_val,        32'd0);
        @(negedge clk);
        reset = 1'b0;
        flush = 1'b0;

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter RESET_BUBBLE, default 1, SHALL mean every ID/EX output register holds a bubble (ex_valid=0, fields zero) after reset.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 reset  in  1  reset is synchronous and active-high.
REQ-004 if_valid  in  1  fetch presents an instruction.
REQ-005 if_ready  out  1  decode accepts the instruction this cycle.
REQ-006 if_instr  in  32  RV32I instruction word.
REQ-007 if_pc  in  32  PC of if_instr.
REQ-008 rf_srcA, rf_srcB  out  5  register file read addresses.
REQ-009 rf_outputA, rf_outputB  in  32  register file read data for rf_srcA and rf_srcB; valid by negedge clk.
REQ-010 ex_ready  in  1  execute consumes the ID/EX register this cycle.
REQ-011 ex_valid  out  1  ID/EX register holds a live instruction.
REQ-012 ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  32 each  registered operands.
REQ-013 ex_rs1, ex_rs2, ex_rd  out  5 each  registered register indices.
REQ-014 ex_alu_op  out  4  alu_op_t; ex_ctrl out 8: {reg_write, mem_read, mem_write, branch, jal, jalr, alu_src_imm, illegal}.
REQ-015 ex_load_pending  in  1  instruction in execute is a load; ex_load_rd in 5 is its destination.
REQ-016 flush  in  1  redirect from a taken branch or jump; kill younger work.

Function
REQ-017 rf_srcA SHALL equal if_instr[19:15] and rf_srcB SHALL equal if_instr[24:20], combinationally, regardless of if_valid.
REQ-018 Register file data SHALL be sampled at the posedge that accepts the instruction (one-cycle latency, if_instr to ex_*).
REQ-019 A hazard SHALL exist when ex_load_pending=1, ex_load_rd!=0, and ex_load_rd equals a source the opcode actually uses (rs1 for all but LUI/AUIPC/JAL; rs2 for R-type, store, branch).
REQ-020 advance = !ex_valid || ex_ready; if_ready SHALL be advance && !hazard && !flush.
REQ-021 On advance: if if_valid && if_ready, load ID/EX with the decoded instruction and set ex_valid=1; otherwise load a bubble (ex_valid=0, ex_ctrl=0).
REQ-022 When advance=0 (no flush), all ID/EX outputs SHALL hold their values.
REQ-023 flush SHALL clear ex_valid and ex_ctrl at the next posedge, override hold and hazard, and drop the instruction presented that cycle.
REQ-024 Immediates SHALL be sign-extended from bit 31 per I, S, B, U and J formats; B and J bit 0 SHALL be 0; U SHALL be {instr[31:12],12'b0}.
REQ-025 Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM (treated as a NOP), SYSTEM (treated as a NOP). Any other opcode SHALL set illegal=1 and reg_write=0.
REQ-026 reg_write SHALL be forced to 0 when rd=0.
REQ-027 ex_alu_op SHALL encode ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND and PASSB (LUI). SUB and SRA SHALL be selected by funct7[5]; OP-IMM SHALL never produce SUB.

Reset
REQ-028 While reset=1, at posedge: ex_valid=0, all ex_* fields=0; if_ready SHALL be 0 during reset.
REQ-029 reset asserted mid-stall or together with flush SHALL yield the same result as REQ-028; reset SHALL take priority.

Structure
REQ-030 Package rv_pkg SHALL hold the opcode localparams, alu_op_t, imm_fmt_t and the ex_ctrl bit positions.
REQ-031 Immediate generation SHALL be a sub-module imm_gen (instr, fmt -> imm), purely combinational.
REQ-032 The ID/EX register SHALL be a single always_ff block; decode SHALL be always_comb.

Verification
REQ-033 Reset, then if_valid with addi x5,x1,-3 (0xFFD08293), rf_outputA=10 -> next cycle: ex_valid=1, ex_rd=5, ex_imm=0xFFFFFFFD, ex_alu_op=ADD, alu_src_imm=1, ex_rs1_val=10.
REQ-034 sw x2,8(x3) (0x0021A423) -> rf_srcA=3, rf_srcB=2, ex_imm=8, mem_write=1, reg_write=0.
REQ-035 ex_valid=1, ex_load_pending=1, ex_load_rd=5, incoming add x6,x5,x1 -> if_ready=0 and a bubble is inserted; after ex_load_pending drops, the add is accepted.
REQ-036 ex_ready=0 for 3 cycles with ex_valid=1 -> ID/EX is stable and if_ready=0; flush during the stall -> ex_valid=0 next cycle.
REQ-037 lui x7,0x12345 (0x123453B7) -> ex_imm=0x12345000, ex_alu_op=PASSB; opcode 0x7F -> illegal=1, reg_write=0.
REQ-038 addi x0,x0,1 -> ex_valid=1, reg_write=0.
